// File: rtl/elevator_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_stim_pkg
// Description : Shared types and constants for the hall-call stimulus
//               sequencer: direction encodings, FSM state enum, a default
//               table entry layout, the LFSR seed and an entry legality
//               helper.
// Options     : REQ_STIM_RAND_MODE_EN (consumer of LFSR_SEED)
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_stim_pkg;

    localparam logic        DIR_UP    = 1'b1;
    localparam logic        DIR_DOWN  = 1'b0;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } stim_state_t;

    // Entry layout for the default configuration (8 floors, 8-bit delay).
    // The sequencer declares the same layout at its own parameter widths.
    localparam int unsigned STIM_FLOOR_W = 3;
    localparam int unsigned STIM_DELAY_W = 8;

    typedef struct packed {
        logic [STIM_FLOOR_W-1:0] floor;
        logic                    dir;
        logic [STIM_DELAY_W-1:0] delay;
    } stim_entry_t;

    // A request is illegal if the floor does not exist, or if it asks to go
    // down from the bottom floor or up from the top floor.
    function automatic logic stim_entry_legal(input int unsigned floor,
                                              input logic        dir,
                                              input int unsigned num_floors);
        if (floor >= num_floors)                        return 1'b0;
        if ((floor == 0) && (dir == DIR_DOWN))          return 1'b0;
        if ((floor == num_floors - 1) && (dir == DIR_UP)) return 1'b0;
        return 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : stim_lfsr
// Description : 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable.
//               Exposes both the current state and the value it would take
//               on the next step.
// Options     : module exists only when REQ_STIM_RAND_MODE_EN is defined
// Ports       : clk, reset (async, active-low), step_i, state_o, next_o
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef REQ_STIM_RAND_MODE_EN
module stim_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_i,
    output logic [15:0] state_o,
    output logic [15:0] next_o
);

    logic [15:0] lfsr_q;

    assign next_o  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign state_o = lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (step_i) begin
            lfsr_q <= next_o;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/request_stim_seq.sv
`default_nettype none
// ============================================================================
// Module      : request_stim_seq
// Description : Programmable hall-call stimulus sequencer. Replays a table of
//               {floor, dir, delay} entries into the elevator controller's
//               request interface with a ready handshake, optional looping
//               and skipping of illegal entries (flagged on err).
// Options     : REQ_STIM_RAND_MODE_EN - adds LFSR-generated random requests
//               selected by rand_mode at start.
// Ports       : clk, reset (async, active-low)
//               cfg_we/cfg_addr/cfg_floor/cfg_dir/cfg_delay : table write
//               cfg_len, cfg_traffic, loop_en, rand_mode    : sampled at start
//               start, stop                                 : control
//               request_ready                               : handshake in
//               request/request_floor/request_dir           : request out
//               traffic_state, busy, done, err, entry_idx   : status
// Revision    : 1.0 - initial release
// ============================================================================
module request_stim_seq
    import elevator_stim_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_W      = $clog2(DEPTH),
    parameter int unsigned DELAY_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [FLOOR_W-1:0] cfg_floor,
    input  logic               cfg_dir,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [IDX_W:0]     cfg_len,
    input  logic [1:0]         cfg_traffic,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    input  logic               rand_mode,
    input  logic               request_ready,
    output logic               request,
    output logic [FLOOR_W-1:0] request_floor,
    output logic               request_dir,
    output logic [1:0]         traffic_state,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [IDX_W-1:0]   entry_idx
);

    typedef struct packed {
        logic [FLOOR_W-1:0] floor;
        logic               dir;
        logic [DELAY_W-1:0] delay;
    } entry_t;

    entry_t             table_q [DEPTH];
    stim_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [IDX_W:0]     len_q, len_d;
    logic               loop_q, loop_d;
    logic [1:0]         traffic_q, traffic_d;
    logic               req_q, req_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               w_launch;
    logic               w_step;
    logic               w_adv;
    logic               w_more;
    logic [IDX_W-1:0]   w_adv_idx;
    entry_t             w_cur;
    logic               w_cur_legal;
    logic [DELAY_W-1:0] w_entry0_delay;
    logic [DELAY_W-1:0] w_start_delay;
    logic [DELAY_W-1:0] w_adv_delay;

    // Table storage is deliberately not reset. Writes are only accepted
    // while no sequence is running.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) begin
            table_q[cfg_addr] <= '{floor: cfg_floor, dir: cfg_dir, delay: cfg_delay};
        end
    end

    // A write to entry 0 in the start cycle must be seen by start, so bypass
    // the table for the first delay.
    assign w_entry0_delay = (cfg_we && (cfg_addr == '0)) ? cfg_delay : table_q[0].delay;

    assign w_more    = (({1'b0, idx_q} + (IDX_W+1)'(1)) < len_q);
    assign w_adv_idx = w_more ? (idx_q + IDX_W'(1)) : '0;

`ifdef REQ_STIM_RAND_MODE_EN
    logic        rand_q;
    logic [15:0] w_lfsr;
    logic [15:0] w_lfsr_nxt;

    // Random entries are always legal: the edge floors get their only
    // meaningful direction.
    function automatic entry_t lfsr_entry(input logic [15:0] s);
        entry_t e;
        e.floor = FLOOR_W'(s % 16'(NUM_FLOORS));
        e.delay = s[DELAY_W-1:0];
        if (e.floor == '0)                         e.dir = DIR_UP;
        else if (32'(e.floor) == NUM_FLOORS - 1)   e.dir = DIR_DOWN;
        else                                       e.dir = s[15];
        return e;
    endfunction

    stim_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step_i  (w_step && rand_q),
        .state_o (w_lfsr),
        .next_o  (w_lfsr_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rand_q <= 1'b0;
        end else if (w_launch) begin
            rand_q <= rand_mode;
        end
    end

    // The LFSR steps on acceptance, so the delay of the following entry
    // comes from the post-step value.
    assign w_cur         = rand_q ? lfsr_entry(w_lfsr) : table_q[idx_q];
    assign w_start_delay = rand_mode ? lfsr_entry(w_lfsr).delay : w_entry0_delay;
    assign w_adv_delay   = rand_q ? lfsr_entry(w_lfsr_nxt).delay : table_q[w_adv_idx].delay;
`else
    logic w_unused_rand;

    assign w_cur         = table_q[idx_q];
    assign w_start_delay = w_entry0_delay;
    assign w_adv_delay   = table_q[w_adv_idx].delay;
    assign w_unused_rand = rand_mode ^ w_step;
`endif

    assign w_cur_legal = stim_entry_legal(32'(w_cur.floor), w_cur.dir, NUM_FLOORS);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        loop_d    = loop_q;
        traffic_d = traffic_q;
        req_d     = req_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        done_d    = done_q;
        err_d     = err_q;
        w_launch  = 1'b0;
        w_step    = 1'b0;
        w_adv     = 1'b0;

        if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            req_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        err_d = 1'b0;
                        if (cfg_len == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            w_launch  = 1'b1;
                            len_d     = cfg_len;
                            loop_d    = loop_en;
                            traffic_d = cfg_traffic;
                            idx_d     = '0;
                            cnt_d     = w_start_delay;
                            done_d    = 1'b0;
                            state_d   = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end else if (w_cur_legal) begin
                        state_d = ISSUE;
                        req_d   = 1'b1;
                        floor_d = w_cur.floor;
                        dir_d   = w_cur.dir;
                    end else begin
                        // Skip without ever raising request.
                        err_d = 1'b1;
                        w_adv = 1'b1;
                    end
                end
                ISSUE: begin
                    if (request_ready) begin
                        req_d  = 1'b0;
                        w_step = 1'b1;
                        w_adv  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (w_adv) begin
                if (w_more || loop_q) begin
                    idx_d   = w_adv_idx;
                    cnt_d   = w_adv_delay;
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                end
            end
        end

        busy_d = (state_d == WAIT) || (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            traffic_q <= 2'b00;
            req_q     <= 1'b0;
            floor_q   <= '0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            traffic_q <= traffic_d;
            req_q     <= req_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign request       = req_q;
    assign request_floor = floor_q;
    assign request_dir   = dir_q;
    assign traffic_state = traffic_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign entry_idx     = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_request_stim_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_request_stim_seq
// Description : Self-checking bench for request_stim_seq. Expected requests
//               are queued when a sequence is launched and popped whenever
//               the DUT hands over an accepted request. Random-mode section
//               is built only with REQ_STIM_RAND_MODE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_request_stim_seq;

    localparam int NF = 8;
    localparam int FW = 4;   // wide enough to hold out-of-range floors
    localparam int DP = 16;
    localparam int IW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [FW-1:0] cfg_floor;
    logic          cfg_dir;
    logic [DW-1:0] cfg_delay;
    logic [IW:0]   cfg_len;
    logic [1:0]    cfg_traffic;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic          rand_mode;
    logic          request_ready;
    logic          request;
    logic [FW-1:0] request_floor;
    logic          request_dir;
    logic [1:0]    traffic_state;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] entry_idx;

    typedef struct {
        int   floor;
        logic dir;
    } req_t;

    typedef struct {
        int   floor;
        logic dir;
        int   delay;
        logic legal;
    } vec_t;

    req_t sb[$];
    vec_t vecs[8];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_accepted = 0;
    logic pat_req[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   pat_floor[6] = '{3, 0, 5, 0, 2, 0};

    request_stim_seq #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .DEPTH      (DP),
        .IDX_W      (IW),
        .DELAY_W    (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_floor     (cfg_floor),
        .cfg_dir       (cfg_dir),
        .cfg_delay     (cfg_delay),
        .cfg_len       (cfg_len),
        .cfg_traffic   (cfg_traffic),
        .loop_en       (loop_en),
        .start         (start),
        .stop          (stop),
        .rand_mode     (rand_mode),
        .request_ready (request_ready),
        .request       (request),
        .request_floor (request_floor),
        .request_dir   (request_dir),
        .traffic_state (traffic_state),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .entry_idx     (entry_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int fl, input logic d);
        req_t r;
        r.floor = fl;
        r.dir   = d;
        sb.push_back(r);
    endtask

    task automatic write_entry(input int a, input int fl, input logic d, input int dl);
        cfg_we    = 1'b1;
        cfg_addr  = IW'(a);
        cfg_floor = FW'(fl);
        cfg_dir   = d;
        cfg_delay = DW'(dl);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start_seq(input int len, input logic lp, input logic [1:0] tr);
        cfg_len     = (IW+1)'(len);
        loop_en     = lp;
        cfg_traffic = tr;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (!request && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
    endtask

    // Scoreboard: every accepted request must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && request && request_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got floor %0d dir %0d, expected no request",
                         request_floor, request_dir);
            end else begin
                req_t r;
                r = sb.pop_front();
                chk("sb_floor", 32'(request_floor), 32'(r.floor));
                chk("sb_dir", 32'(request_dir), 32'(r.dir));
            end
            n_accepted++;
        end
    end

    initial begin
        int n;
        int base;

        vecs[0] = '{0, 1'b0, 0, 1'b0};
        vecs[1] = '{7, 1'b1, 0, 1'b0};
        vecs[2] = '{9, 1'b1, 0, 1'b0};
        vecs[3] = '{2, 1'b1, 0, 1'b1};
        vecs[4] = '{7, 1'b0, 2, 1'b1};
        vecs[5] = '{0, 1'b1, 1, 1'b1};
        vecs[6] = '{8, 1'b0, 0, 1'b0};
        vecs[7] = '{5, 1'b0, 3, 1'b1};

        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_floor = '0; cfg_dir = 1'b0;
        cfg_delay = '0; cfg_len = '0; cfg_traffic = 2'b00; loop_en = 1'b0;
        start = 1'b0; stop = 1'b0; rand_mode = 1'b0; request_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_request", 32'(request), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_idx", 32'(entry_idx), 0);
        chk("rst_traffic", 32'(traffic_state), 0);
        reset = 1'b1;
        tick();

        // 1: three zero-delay entries, ready always high
        write_entry(0, 3, 1'b1, 0);
        write_entry(1, 5, 1'b0, 0);
        write_entry(2, 2, 1'b0, 0);
        request_ready = 1'b1;
        push_exp(3, 1'b1); push_exp(5, 1'b0); push_exp(2, 1'b0);
        start_seq(3, 1'b0, 2'd2);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_traffic", 32'(traffic_state), 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t1_req_c%0d", i), 32'(request), 32'(pat_req[i]));
            if (pat_req[i]) chk($sformatf("t1_floor_c%0d", i), 32'(request_floor), 32'(pat_floor[i]));
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // 2: delay 10 written in the start cycle, ready held low
        request_ready = 1'b0;
        push_exp(4, 1'b1);
        cfg_we = 1'b1; cfg_addr = '0; cfg_floor = 4'd4; cfg_dir = 1'b1; cfg_delay = 8'd10;
        cfg_len = 5'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        wait_req(20, n);
        chk("t2_latency", 32'(n), 11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_req", 32'(request), 1);
            chk("t2_hold_floor", 32'(request_floor), 4);
            chk("t2_hold_dir", 32'(request_dir), 1);
        end
        request_ready = 1'b1;
        tick();
        chk("t2_drop", 32'(request), 0);
        chk("t2_done", 32'(done), 1);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // 3: vector table with illegal entries mixed in
        for (int i = 0; i < 8; i++) begin
            write_entry(i, vecs[i].floor, vecs[i].dir, vecs[i].delay);
            if (vecs[i].legal) push_exp(vecs[i].floor, vecs[i].dir);
        end
        start_seq(8, 1'b0, 2'd1);
        wait_done(200, "t3");
        chk("t3_err", 32'(err), 1);
        chk("t3_idx", 32'(entry_idx), 7);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_done", 32'(done), 0);
        chk("t3_stop_err_kept", 32'(err), 1);

        // 4: looping two entries, then stop mid-ISSUE
        write_entry(0, 1, 1'b1, 0);
        write_entry(1, 6, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 1'b1);
            push_exp(6, 1'b0);
        end
        base = n_accepted;
        request_ready = 1'b1;
        start_seq(2, 1'b1, 2'd0);
        chk("t4_err_cleared", 32'(err), 0);
        n = 0;
        while ((n_accepted - base) < 6 && n < 100) begin
            tick();
            n++;
        end
        request_ready = 1'b0;
        chk("t4_accepted", 32'(n_accepted - base), 6);
        wait_req(20, n);
        chk("t4_reissue", 32'(request), 1);
        chk("t4_reissue_floor", 32'(request_floor), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_req", 32'(request), 0);
        chk("t4_stop_busy", 32'(busy), 0);
        chk("t4_stop_done", 32'(done), 0);
        tick(); tick();
        chk("t4_idle_req", 32'(request), 0);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // 5: async reset during WAIT and during ISSUE, then replay
        write_entry(0, 4, 1'b1, 10);
        start_seq(1, 1'b0, 2'd3);
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        chk("t5w_req", 32'(request), 0);
        chk("t5w_busy", 32'(busy), 0);
        chk("t5w_done", 32'(done), 0);
        chk("t5w_idx", 32'(entry_idx), 0);
        chk("t5w_traffic", 32'(traffic_state), 0);
        reset = 1'b1;
        tick();
        start_seq(1, 1'b0, 2'd3);
        wait_req(20, n);
        chk("t5i_rise", 32'(request), 1);
        #2 reset = 1'b0;
        #1;
        chk("t5i_req", 32'(request), 0);
        chk("t5i_busy", 32'(busy), 0);
        reset = 1'b1;
        tick();
        push_exp(4, 1'b1);
        request_ready = 1'b1;
        start_seq(1, 1'b0, 2'd0);
        wait_req(20, n);
        chk("t5r_latency", 32'(n), 11);
        wait_done(20, "t5r");
        chk("t5r_sb_empty", 32'(sb.size()), 0);

`ifdef REQ_STIM_RAND_MODE_EN
        // 6: random mode against an independent LFSR model
        begin
            logic [15:0] s;
            int          fl;
            logic        d;
            reset = 1'b0;
            #3 reset = 1'b1;
            tick();
            s = 16'hACE1;
            for (int i = 0; i < 16; i++) begin
                fl = int'(s % 16'd8);
                if (fl == 0)           d = 1'b1;
                else if (fl == NF - 1) d = 1'b0;
                else                   d = s[15];
                push_exp(fl, d);
                s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
            end
            base = n_accepted;
            rand_mode = 1'b1;
            request_ready = 1'b1;
            start_seq(16, 1'b0, 2'd0);
            wait_done(6000, "t6");
            chk("t6_err", 32'(err), 0);
            chk("t6_count", 32'(n_accepted - base), 16);
            chk("t6_sb_empty", 32'(sb.size()), 0);
            rand_mode = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
